// File: rtl/gb2_stream_counter.sv
// Stochastic-to-binary back end: counts ones per lane over a 2^LEN_LOG2-beat
// stream and hands the saturated per-lane counts out through valid/ready.
module gb2_stream_counter #(
  parameter int LANES    = 2,
  parameter int LEN_LOG2 = 8,
  parameter int W        = LEN_LOG2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [LANES-1:0]     z,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   count_out,
  output logic [1:0]           state_dbg
);

  // Handshake: a result transfers on any rising clk edge where out_valid and
  // out_ready are both 1; out_valid stays high and count_out stable until then.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [LEN_LOG2-1:0] LAST_BEAT = '1;
  localparam logic [W-1:0]        MAX_OUT   = '1;

  state_t                    state_q, state_d;
  logic [LEN_LOG2-1:0]       beat_q, beat_d;
  logic [LANES-1:0][W:0]     lane_q, lane_d;
  logic [LANES*W-1:0]        count_q, count_d;
  logic                      busy_q, out_valid_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    lane_d  = lane_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          beat_d  = '0;
          lane_d  = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          beat_d = beat_q + 1'b1;
          for (int i = 0; i < LANES; i++) begin
            lane_d[i] = lane_q[i] + {{W{1'b0}}, z[i]};
          end
          if (beat_q == LAST_BEAT) begin
            state_d = S_HOLD;
            // Only a full all-ones stream reaches 2^W; clamp it to fit W bits.
            for (int i = 0; i < LANES; i++) begin
              count_d[i*W +: W] = lane_d[i][W] ? MAX_OUT : lane_d[i][W-1:0];
            end
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          if (start) begin
            beat_d  = '0;
            lane_d  = '0;
            state_d = S_ACCUM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      lane_q      <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      lane_q      <= lane_d;
      count_q     <= count_d;
      busy_q      <= (state_d == S_ACCUM);
      out_valid_q <= (state_d == S_HOLD);
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign count_out = count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_gb2_stream_counter.sv
// Directed bench for gb2_stream_counter at default parameters (L=256, W=8).
module tb_gb2_stream_counter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [1:0]  z;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] count_out;
  logic [1:0]  state_dbg;

  int n_cmp;
  int n_fail;

  gb2_stream_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .z         (z),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count_out (count_out),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [1:0] zv);
    in_valid = 1'b1;
    z        = zv;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; z = 2'b00; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    n_cmp++;
    if ({busy, out_valid, count_out, state_dbg} !== {1'b0, 1'b0, 16'h0000, 2'd0}) begin
      n_fail++;
      $display("FAIL reset: busy=%b out_valid=%b count=%h state=%0d, want 0 0 0000 0",
               busy, out_valid, count_out, state_dbg);
    end
    // in_valid in IDLE must not start anything
    drive_beat(2'b11);
    n_cmp++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_ignore: busy=%b out_valid=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_saturate();
    do_start();
    n_cmp++;
    if (busy !== 1'b1 || state_dbg !== 2'd1) begin
      n_fail++;
      $display("FAIL sat_busy: busy=%b state=%0d, want 1 1", busy, state_dbg);
    end
    for (int b = 0; b < 255; b++) drive_beat(2'b01);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_early: out_valid=%b busy=%b after 255 beats, want 0 1", out_valid, busy);
    end
    drive_beat(2'b01);
    n_cmp++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || state_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL sat_latency: out_valid=%b busy=%b state=%0d, want 1 0 2",
               out_valid, busy, state_dbg);
    end
    n_cmp++;
    if (count_out !== {8'd0, 8'd255}) begin
      n_fail++;
      $display("FAIL sat_count: got %h want %h", count_out, {8'd0, 8'd255});
    end
    consume();
    n_cmp++;
    if (out_valid !== 1'b0 || state_dbg !== 2'd0 || count_out !== {8'd0, 8'd255}) begin
      n_fail++;
      $display("FAIL sat_consume: out_valid=%b state=%0d count=%h, want 0 0 00ff",
               out_valid, state_dbg, count_out);
    end
  endtask

  task automatic test_alternate();
    do_start();
    for (int b = 0; b < 256; b++) drive_beat(b[0] ? 2'b10 : 2'b01);
    n_cmp++;
    if (out_valid !== 1'b1 || count_out !== {8'd128, 8'd128}) begin
      n_fail++;
      $display("FAIL alternate: out_valid=%b count=%h, want 1 %h",
               out_valid, count_out, {8'd128, 8'd128});
    end
    consume();
  endtask

  task automatic test_gaps();
    int gaps_left;
    int g;
    gaps_left = 144;
    do_start();
    for (int b = 0; b < 256; b++) begin
      if (gaps_left > 0 && $urandom_range(0, 2) == 0) begin
        g = $urandom_range(1, 3);
        if (g > gaps_left) g = gaps_left;
        gaps_left -= g;
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          z = 2'($urandom_range(0, 3));
          step();
        end
      end
      if (b == 255) begin
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL gaps_early: out_valid=%b busy=%b, want 0 1", out_valid, busy);
        end
      end
      drive_beat((b % 3 == 0) ? 2'b11 : 2'b00);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || count_out !== {8'd86, 8'd86}) begin
      n_fail++;
      $display("FAIL gaps_count: out_valid=%b count=%h, want 1 %h",
               out_valid, count_out, {8'd86, 8'd86});
    end
    consume();
  endtask

  task automatic test_back_to_back();
    do_start();
    for (int b = 0; b < 256; b++) drive_beat(2'b01);
    in_valid = 1'b1; z = 2'b11; start = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || busy !== 1'b0 || count_out !== {8'd0, 8'd255}) begin
        n_fail++;
        $display("FAIL backpressure c%0d: out_valid=%b busy=%b count=%h, want 1 0 00ff",
                 c, out_valid, busy, count_out);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart: busy=%b out_valid=%b, want 1 0", busy, out_valid);
    end
    for (int b = 0; b < 256; b++) drive_beat(2'b10);
    n_cmp++;
    if (out_valid !== 1'b1 || count_out !== {8'd255, 8'd0}) begin
      n_fail++;
      $display("FAIL b2b_count: out_valid=%b count=%h, want 1 %h",
               out_valid, count_out, {8'd255, 8'd0});
    end
    consume();
  endtask

  task automatic test_mid_reset();
    do_start();
    for (int b = 0; b < 100; b++) drive_beat(2'b11);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if ({busy, out_valid, count_out, state_dbg} !== {1'b0, 1'b0, 16'h0000, 2'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b out_valid=%b count=%h state=%0d, want 0 0 0000 0",
               busy, out_valid, count_out, state_dbg);
    end
    do_start();
    for (int b = 0; b < 255; b++) drive_beat(2'b00);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_early: out_valid=%b after 255 beats, want 0", out_valid);
    end
    drive_beat(2'b00);
    n_cmp++;
    if (out_valid !== 1'b1 || count_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_fresh: out_valid=%b count=%h, want 1 0000", out_valid, count_out);
    end
    consume();
  endtask

  task automatic test_ignored_start();
    do_start();
    for (int b = 0; b < 255; b++) begin
      start = (b == 50);
      drive_beat(2'b01);
      start = 1'b0;
    end
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL istart_early: out_valid=%b busy=%b, want 0 1", out_valid, busy);
    end
    drive_beat(2'b01);
    n_cmp++;
    if (out_valid !== 1'b1 || count_out !== {8'd0, 8'd255}) begin
      n_fail++;
      $display("FAIL istart_count: out_valid=%b count=%h, want 1 00ff", out_valid, count_out);
    end
    start = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    start = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || count_out !== {8'd0, 8'd255}) begin
      n_fail++;
      $display("FAIL istart_hold: out_valid=%b busy=%b count=%h, want 1 0 00ff",
               out_valid, busy, count_out);
    end
    consume();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL istart_idle: out_valid=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_saturate();
    test_alternate();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
